// File: rtl/led_div_ctrl.sv
// Button front end for the LED blink counter: synchronise, debounce, step the divider on
// each accepted press, and restore the power-on divider after a long hold.
module led_div_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 200_000_000,
  parameter logic [4:0]  DIV_MIN      = 5'd1,
  parameter logic [4:0]  DIV_MAX      = 5'd20,
  parameter logic [4:0]  DIV_RST      = 5'd6
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic       btn_i,
  output logic [4:0] div_o,
  output logic       wren_o
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned LW = $clog2(LONG_CYC + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [DW-1:0] DSAT  = DW'(DEBOUNCE_CYC);
  localparam logic [LW-1:0] LLAST = LW'(LONG_CYC - 1);
  localparam logic [LW-1:0] LSAT  = LW'(LONG_CYC);

  if (!(DIV_MIN >= 5'd1 && DIV_MIN <= DIV_RST && DIV_RST <= DIV_MAX && DIV_MAX <= 5'd20 &&
        DEBOUNCE_CYC >= 1 && LONG_CYC >= 1)) begin : g_bad_params
    $error("led_div_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

  state_t        state_q;
  logic [1:0]    sync_q;
  logic [DW-1:0] dcnt_q;
  logic [LW-1:0] lcnt_q;
  logic          fired_q;
  logic [4:0]    div_q;
  logic          wren_q;
  logic          btn_s;
  logic [4:0]    div_step_d;
  logic [DW-1:0] dcnt_inc;
  logic [LW-1:0] lcnt_inc;

  assign btn_s  = sync_q[1];
  assign div_o  = div_q;
  assign wren_o = wren_q;

  // Counters saturate rather than wrap.
  assign dcnt_inc = (dcnt_q == DSAT) ? dcnt_q : dcnt_q + 1'b1;
  assign lcnt_inc = (lcnt_q == LSAT) ? lcnt_q : lcnt_q + 1'b1;

  // Out-of-range values (only reachable through odd parameter sets) fall back to DIV_MIN.
  always_comb begin
    div_step_d = div_q + 5'd1;
    if (div_q < DIV_MIN || div_q >= DIV_MAX) div_step_d = DIV_MIN;
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      dcnt_q  <= '0;
      lcnt_q  <= '0;
      fired_q <= 1'b0;
      div_q   <= DIV_RST;
      wren_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      wren_q <= 1'b0;
      case (state_q)
        IDLE: if (btn_s) begin
          if (DEBOUNCE_CYC == 1) begin
            state_q <= HELD;
            div_q   <= div_step_d;
            wren_q  <= 1'b1;
            lcnt_q  <= '0;
            fired_q <= 1'b0;
          end else begin
            state_q <= ARM;
            dcnt_q  <= DW'(1);
          end
        end
        ARM: begin
          if (!btn_s) begin
            state_q <= IDLE;
          end else if (dcnt_q >= DLAST) begin
            state_q <= HELD;
            div_q   <= div_step_d;
            wren_q  <= 1'b1;
            lcnt_q  <= '0;
            fired_q <= 1'b0;
          end else begin
            dcnt_q <= dcnt_inc;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_q <= REL;
            dcnt_q  <= DW'(1);
          end else if (!fired_q) begin
            if (lcnt_q == LLAST) begin
              div_q   <= DIV_RST;
              wren_q  <= 1'b1;
              fired_q <= 1'b1;
            end else begin
              lcnt_q <= lcnt_inc;
            end
          end
        end
        REL: begin
          // A bounce back high resumes the same press: no step, fired flag kept.
          if (btn_s) begin
            state_q <= HELD;
            lcnt_q  <= '0;
          end else if (dcnt_q >= DLAST) begin
            state_q <= IDLE;
          end else begin
            dcnt_q <= dcnt_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_div_ctrl.sv
// Bench for led_div_ctrl: directed scenarios plus random button traffic, checked every
// cycle against a run-length model of the debounce/step/restore rules.
module tb_led_div_ctrl;
  localparam int D = 4;
  localparam int L = 20;

  logic       clk100 = 1'b0;
  logic       rst;
  logic       btn_i;
  logic [4:0] div_o;
  logic       wren_o;

  led_div_ctrl #(
    .DEBOUNCE_CYC(D), .LONG_CYC(L),
    .DIV_MIN(5'd1), .DIV_MAX(5'd20), .DIV_RST(5'd6)
  ) dut (
    .clk100(clk100), .rst(rst), .btn_i(btn_i), .div_o(div_o), .wren_o(wren_o)
  );

  always #5 clk100 = ~clk100;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model: debounced level flips after D consecutive opposite samples of the synchronised
  // button; hold counts high samples since the press was accepted or resumed.
  bit m_s1, m_s2, m_pressed, m_fired, m_wren;
  int m_run, m_hold, m_div;
  int cyc, pulses, last_wren_cyc;
  logic prev_wren;

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_pressed = 0; m_fired = 0; m_wren = 0;
    m_run = 0; m_hold = 0; m_div = 6;
  endfunction

  function automatic void model_edge(input bit b);
    bit s;
    if (rst) begin
      model_reset();
      return;
    end
    s = m_s2; m_s2 = m_s1; m_s1 = b;
    m_wren = 0;
    if (!m_pressed) begin
      m_run = s ? m_run + 1 : 0;
      if (m_run == D) begin
        m_pressed = 1; m_run = 0; m_hold = 0; m_fired = 0;
        m_div  = (m_div >= 20 || m_div < 1) ? 1 : m_div + 1;
        m_wren = 1;
      end
    end else if (s) begin
      m_run = 0;
      m_hold++;
      if (!m_fired && m_hold == L) begin
        m_fired = 1; m_div = 6; m_wren = 1;
      end
    end else begin
      m_hold = -1;
      m_run++;
      if (m_run == D) begin
        m_pressed = 0; m_run = 0;
      end
    end
  endfunction

  task automatic tick(input bit b);
    btn_i = b;
    @(posedge clk100);
    #1;
    cyc++;
    model_edge(b);
    if (wren_o === 1'b1) begin
      pulses++;
      last_wren_cyc = cyc;
    end
    chk("wren", {31'd0, wren_o}, {31'd0, m_wren});
    chk("div", {27'd0, div_o}, m_div);
    chk("no_back2back", {31'd0, wren_o & prev_wren}, 0);
    prev_wren = wren_o;
  endtask

  task automatic press(input int hi, input int lo);
    repeat (hi) tick(1'b1);
    repeat (lo) tick(1'b0);
  endtask

  task automatic goto_div(input int target);
    for (int i = 0; i < 25 && m_div != target; i++) press(6, 6);
    chk("goto_div", {27'd0, div_o}, target);
  endtask

  initial begin
    int t0, n;
    cyc = 0; pulses = 0; last_wren_cyc = -1; prev_wren = 1'b0;
    model_reset();
    rst = 1'b1; btn_i = 1'b0;
    repeat (3) tick(1'b0);
    chk("reset_div", {27'd0, div_o}, 6);
    chk("reset_wren", {31'd0, wren_o}, 0);
    rst = 1'b0;

    // Idle for 100 cycles
    repeat (100) tick(1'b0);
    chk("idle_pulses", pulses, 0);
    chk("idle_div", {27'd0, div_o}, 6);

    // Clean press: latency and single step
    pulses = 0;
    t0 = cyc + 1;
    press(10, 10);
    chk("press_pulses", pulses, 1);
    chk("press_latency", last_wren_cyc - t0, D + 1);
    chk("press_div", {27'd0, div_o}, 7);

    // Bounce pattern shorter than the debounce window
    pulses = 0;
    repeat (4) press(3, 1);
    press(3, 10);
    chk("bounce_pulses", pulses, 0);
    chk("bounce_div", {27'd0, div_o}, 7);

    // Wrap at DIV_MAX and 15 steps
    goto_div(20);
    pulses = 0;
    repeat (15) press(6, 6);
    chk("seq_pulses", pulses, 15);
    chk("seq_div", {27'd0, div_o}, 15);
    goto_div(20);
    press(6, 6);
    chk("wrap_div", {27'd0, div_o}, 1);

    // Long hold: step then restore L cycles later
    goto_div(9);
    pulses = 0;
    press(40, 10);
    chk("long_pulses", pulses, 2);
    chk("long_div", {27'd0, div_o}, 6);

    // Reset two cycles into ARM with the button still held
    pulses = 0;
    repeat (4) tick(1'b1);
    rst = 1'b1;
    repeat (3) tick(1'b1);
    chk("rst_mid_pulses", pulses, 0);
    chk("rst_mid_div", {27'd0, div_o}, 6);
    rst = 1'b0;
    t0 = cyc;
    press(12, 8);
    chk("rst_after_pulses", pulses, 1);
    chk("rst_after_latency", last_wren_cyc - t0, D + 2);
    chk("rst_after_div", {27'd0, div_o}, 7);

    // Release bounce after a restore must not re-step or re-restore
    pulses = 0;
    press(30, 2); press(3, 2); press(25, 10);
    chk("relbounce_pulses", pulses, 2);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick($urandom_range(0, 1) == 1);
        rst = 1'b0;
      end
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 8);
      repeat (n) tick(($urandom_range(0, 1) == 1));
    end
    repeat (20) tick(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end
endmodule
